// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU sequencer: opcode constants,
// sequencer state encoding and opcode classification helpers.
package alu_pkg;

  localparam int OPCODE_W = 5;

  // Single-cycle opcodes (combinational ALU, result valid during EXEC)
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'h00;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'h01;
  // Multi-cycle opcodes (ALU started with alu_start, finishes with alu_valid)
  localparam logic [OPCODE_W-1:0] OP_MULT = 5'h02;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'h03;
  // More single-cycle opcodes
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'h04;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'h05;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 5'h06;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'h07;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'h08;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'h09;
  localparam logic [OPCODE_W-1:0] OP_SRA  = 5'h0A;
  localparam logic [OPCODE_W-1:0] OP_CMP  = 5'h0B;
  localparam logic [OPCODE_W-1:0] OP_PASS = 5'h0C;
  localparam logic [OPCODE_W-1:0] OP_INC  = 5'h0D;
  localparam logic [OPCODE_W-1:0] OP_DEC  = 5'h0E;
  // Everything from here up is reserved and answered with an error response
  localparam logic [OPCODE_W-1:0] OP_FIRST_ILLEGAL = 5'h0F;

  // Binary-encoded sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;

  // True for opcodes that need the start/wait handshake with the ALU
  function automatic logic is_multicycle(input logic [OPCODE_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // True for reserved opcodes that never reach the ALU
  function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
    return op >= OP_FIRST_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer -- WAIT watchdog for the ALU sequencer. Cleared by load,
// counts while enabled, and flags expire on the TIMEOUT-th enabled cycle.
// Only instantiated when ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int COUNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(TIMEOUT - 1);

  logic [COUNT_W-1:0] count_reg;

  // expire fires during the last allowed enabled cycle so the FSM leaves at its end
  assign expire = enable && (count_reg == LAST_COUNT);

  // Counter: cleared by reset or load, saturates at the expire point
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer -- accepts one ALU request at a time, drives the operands to
// the ALU, runs the start/wait handshake for multi-cycle ops and holds the
// response until it is taken.
// Optional build macro: ALU_SEQ_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT cycles)
// that aborts a stuck multi-cycle op with an error response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_opcode,
  input  logic [WIDTH-1:0] req_op1,
  input  logic [WIDTH-1:0] req_op2,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [4:0]       opcode,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  input  logic             alu_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             rsp_error
);

  seq_state_e state_reg;
  seq_state_e state_next;

  logic [4:0]       opcode_reg;
  logic [WIDTH-1:0] in1_reg;
  logic [WIDTH-1:0] in2_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic             rsp_flag_reg;
  logic             rsp_error_reg;

  logic accept;
  logic timeout_expire;

  assign accept = req_valid && req_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic timer_load;
  logic timer_enable;

  assign timer_load   = (state_reg == ST_START);
  assign timer_enable = (state_reg == ST_WAIT);

  alu_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .enable (timer_enable),
    .expire (timeout_expire)
  );
`else
  // Without the watchdog a WAIT is left only on alu_valid or reset
  assign timeout_expire = 1'b0;
`endif

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_illegal(req_opcode)) begin
            state_next = ST_RESP;
          end else if (is_multicycle(req_opcode)) begin
            state_next = ST_START;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end
      ST_EXEC:  state_next = ST_RESP;
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (alu_valid || timeout_expire) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state; ready is masked during reset
  always_comb begin
    req_ready = (state_reg == ST_IDLE) && !rst;
    alu_start = (state_reg == ST_START);
    rsp_valid = (state_reg == ST_RESP);
  end

  // Request capture: operands stay on the ALU inputs until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_reg <= '0;
      in1_reg    <= '0;
      in2_reg    <= '0;
    end else if (accept) begin
      opcode_reg <= req_opcode;
      in1_reg    <= req_op1;
      in2_reg    <= req_op2;
    end
  end

  // Response capture; the registers only change on the way into RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result_reg <= '0;
      rsp_flag_reg   <= 1'b0;
      rsp_error_reg  <= 1'b0;
    end else if (accept && is_illegal(req_opcode)) begin
      rsp_result_reg <= '0;
      rsp_flag_reg   <= 1'b0;
      rsp_error_reg  <= 1'b1;
    end else if (state_reg == ST_EXEC) begin
      rsp_result_reg <= alu_result;
      rsp_flag_reg   <= alu_flag;
      rsp_error_reg  <= 1'b0;
    end else if ((state_reg == ST_WAIT) && alu_valid) begin
      // Multi-cycle ops report no flag
      rsp_result_reg <= alu_result;
      rsp_flag_reg   <= 1'b0;
      rsp_error_reg  <= 1'b0;
    end else if ((state_reg == ST_WAIT) && timeout_expire) begin
      rsp_result_reg <= '0;
      rsp_flag_reg   <= 1'b0;
      rsp_error_reg  <= 1'b1;
    end
  end

  assign opcode     = opcode_reg;
  assign alu_in1    = in1_reg;
  assign alu_in2    = in2_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_flag   = rsp_flag_reg;
  assign rsp_error  = rsp_error_reg;

endmodule
